rl_lock_ctrl: RTL

Parametrised successor to the combination-lock state machine: a code-entry controller with configurable code length, digit width, error limit and hold times. It adds backspace editing, timed unlock/error/alarm holds and an admin mode for reprogramming the code. It sits between the debounced switch/button pulse logic and the display/LED drivers of the lock system.

---
 rtl/rl_pkg.sv | 21 ++
 rtl/rl_hold_timer.sv | 28 ++
 rtl/rl_lock_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rl_pkg.sv
// Shared state encodings and helpers for the lock controller.
package rl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT    = 3'd0,
    ST_INPUT   = 3'd1,
    ST_UNLOCK  = 3'd2,
    ST_ERROR   = 3'd3,
    ST_ALARM   = 3'd4,
    ST_PROGRAM = 3'd5
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rl_hold_timer.sv
// Load / count-down counter shared by the ERROR, UNLOCK and ALARM holds.
module rl_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // Loaded with N on entry, the hold ends on the edge that sees the last count.
  assign done = (count <= W'(1));

endmodule

// File: rtl/rl_lock_ctrl.sv
// Code-entry lock controller with backspace editing, timed holds and admin reprogramming.
module rl_lock_ctrl
  import rl_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DIGIT_W    = 4,
  parameter int MAX_ERR    = 3,
  parameter int ERR_HOLD   = 1000,
  parameter int UNLOCK_CYC = 5000,
  parameter int ALARM_CYC  = 20000,
  parameter logic [DIGITS*DIGIT_W-1:0] RESET_CODE = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              digit_vld,
  input  logic [DIGIT_W-1:0]                digit,
  input  logic                              ok,
  input  logic                              backspace,
  input  logic                              admin,
  output logic [STATE_W-1:0]                state,
  output logic                              unlocked,
  output logic                              alarm,
  output logic [$clog2(MAX_ERR+1)-1:0]      err_cnt,
  output logic [$clog2(DIGITS+1)-1:0]       digit_cnt,
  output logic [DIGITS*DIGIT_W-1:0]         entry
);

  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int ERR_W  = $clog2(MAX_ERR + 1);
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int TMR_W  = $clog2(max3(ERR_HOLD, UNLOCK_CYC, ALARM_CYC) + 1);

  state_e              st;
  logic [CODE_W-1:0]   code;
  logic [ERR_W-1:0]    err_next;
  logic                full;
  logic                code_match;
  logic                ok_take;
  logic                bs_take;
  logic                dv_take;
  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_done;

  assign state = st;

  // One pulse per cycle is acted on: ADMIN > OK > BACKSPACE > DIGIT_VLD.
  assign ok_take = ok && !admin;
  assign bs_take = backspace && !admin && !ok;
  assign dv_take = digit_vld && !admin && !ok && !backspace;

  assign full       = (digit_cnt == CNT_W'(DIGITS));
  assign code_match = full && (entry == code);
  assign err_next   = err_cnt + ERR_W'(1);

  // Hold states are only ever entered from INPUT on OK.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (st == ST_INPUT && ok_take) begin
      tmr_load = 1'b1;
      if (code_match)                         tmr_val = TMR_W'(UNLOCK_CYC);
      else if (err_next == ERR_W'(MAX_ERR))   tmr_val = TMR_W'(ALARM_CYC);
      else                                    tmr_val = TMR_W'(ERR_HOLD);
    end
  end

  rl_hold_timer #(.W(TMR_W)) u_hold_timer (
    .clk      (clk),
    .rst_n    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= ST_WAIT;
      unlocked  <= 1'b0;
      alarm     <= 1'b0;
      err_cnt   <= '0;
      digit_cnt <= '0;
      entry     <= '0;
      code      <= RESET_CODE;
    end else begin
      case (st)
        ST_WAIT: begin
          if (dv_take) begin
            st        <= ST_INPUT;
            entry     <= CODE_W'(digit);
            digit_cnt <= CNT_W'(1);
          end
        end

        ST_INPUT, ST_PROGRAM: begin
          if (ok_take) begin
            if (st == ST_INPUT) begin
              entry     <= '0;
              digit_cnt <= '0;
              if (code_match) begin
                st       <= ST_UNLOCK;
                unlocked <= 1'b1;
                err_cnt  <= '0;
              end else begin
                err_cnt <= err_next;
                if (err_next == ERR_W'(MAX_ERR)) begin
                  st    <= ST_ALARM;
                  alarm <= 1'b1;
                end else begin
                  st <= ST_ERROR;
                end
              end
            end else if (full) begin
              code      <= entry;
              entry     <= '0;
              digit_cnt <= '0;
              st        <= ST_WAIT;
            end
          end else if (bs_take) begin
            if (digit_cnt == '0) begin
              st <= ST_WAIT;
            end else begin
              entry     <= entry >> DIGIT_W;
              digit_cnt <= digit_cnt - CNT_W'(1);
              if (st == ST_INPUT && digit_cnt == CNT_W'(1)) st <= ST_WAIT;
            end
          end else if (dv_take && !full) begin
            entry     <= (entry << DIGIT_W) | CODE_W'(digit);
            digit_cnt <= digit_cnt + CNT_W'(1);
          end
        end

        ST_UNLOCK: begin
          if (tmr_done || ok_take) begin
            st       <= ST_WAIT;
            unlocked <= 1'b0;
          end else if (admin) begin
            st       <= ST_PROGRAM;
            unlocked <= 1'b0;
          end
        end

        ST_ERROR: begin
          if (tmr_done) st <= ST_WAIT;
        end

        ST_ALARM: begin
          if (tmr_done) begin
            st      <= ST_WAIT;
            alarm   <= 1'b0;
            err_cnt <= '0;
          end
        end

        default: begin
          st        <= ST_WAIT;
          unlocked  <= 1'b0;
          alarm     <= 1'b0;
          digit_cnt <= '0;
          entry     <= '0;
        end
      endcase
    end
  end

endmodule
